// File: rtl/rs_if.sv
// Dispatch / CDB / issue bundle between a reservation-station array and its
// neighbours. The master side feeds dispatch, wakeup and issue acceptance;
// the slave side (rs_array) answers with readiness, issue fields and occupancy.
interface rs_if #(
  parameter int unsigned NUM_ENT   = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned FU_W      = 3,
  parameter int unsigned PAYLOAD_W = 32
);
  localparam int unsigned CNT_W = $clog2(NUM_ENT + 1);

  // dispatch
  logic                 disp_vld;
  logic                 disp_rdy;
  logic [TAG_W-1:0]     disp_dest_tag;
  logic [TAG_W-1:0]     disp_opa_tag;
  logic [TAG_W-1:0]     disp_opb_tag;
  logic                 disp_opa_rdy;
  logic                 disp_opb_rdy;
  logic [FU_W-1:0]      disp_fu_sel;
  logic [PAYLOAD_W-1:0] disp_payload;
  // result broadcast
  logic                 cdb_vld;
  logic [TAG_W-1:0]     cdb_tag;
  // issue
  logic                 iss_rdy;
  logic                 iss_vld;
  logic [TAG_W-1:0]     iss_dest_tag;
  logic [TAG_W-1:0]     iss_opa_tag;
  logic [TAG_W-1:0]     iss_opb_tag;
  logic [FU_W-1:0]      iss_fu_sel;
  logic [PAYLOAD_W-1:0] iss_payload;
  // control / status
  logic                 flush;
  logic [CNT_W-1:0]     rs_cnt;

  modport master (
    output disp_vld, disp_dest_tag, disp_opa_tag, disp_opb_tag,
           disp_opa_rdy, disp_opb_rdy, disp_fu_sel, disp_payload,
           cdb_vld, cdb_tag, iss_rdy, flush,
    input  disp_rdy, iss_vld, iss_dest_tag, iss_opa_tag, iss_opb_tag,
           iss_fu_sel, iss_payload, rs_cnt
  );

  modport slave (
    input  disp_vld, disp_dest_tag, disp_opa_tag, disp_opb_tag,
           disp_opa_rdy, disp_opb_rdy, disp_fu_sel, disp_payload,
           cdb_vld, cdb_tag, iss_rdy, flush,
    output disp_rdy, iss_vld, iss_dest_tag, iss_opa_tag, iss_opb_tag,
           iss_fu_sel, iss_payload, rs_cnt
  );
endinterface

// File: rtl/rs_array.sv
// Reservation-station array: allocates the lowest free entry on dispatch,
// wakes sources from the CDB, and issues the oldest ready entry chosen by
// an age matrix (age[i][j] = 1 means entry j is older than entry i).
// Optional feature macro: RS_DISP_BYPASS_EN -- a dispatch also captures a
// same-cycle CDB broadcast that matches one of its source tags.
module rs_array #(
  parameter int unsigned NUM_ENT   = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned FU_W      = 3,
  parameter int unsigned PAYLOAD_W = 32
) (
  input logic  clk,
  input logic  rst,
  rs_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_ENT);
  localparam int unsigned CNT_W = $clog2(NUM_ENT + 1);

  logic [NUM_ENT-1:0]   vld;
  logic [NUM_ENT-1:0]   opa_rdy;
  logic [NUM_ENT-1:0]   opb_rdy;
  logic [TAG_W-1:0]     dest_tag [NUM_ENT];
  logic [TAG_W-1:0]     opa_tag  [NUM_ENT];
  logic [TAG_W-1:0]     opb_tag  [NUM_ENT];
  logic [FU_W-1:0]      fu_sel   [NUM_ENT];
  logic [PAYLOAD_W-1:0] payload  [NUM_ENT];
  logic [NUM_ENT-1:0]   age      [NUM_ENT];
  logic [CNT_W-1:0]     cnt;

  logic [NUM_ENT-1:0]   elig;
  logic [NUM_ENT-1:0]   sel_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     free_idx;
  logic                 disp_rdy_c;
  logic                 iss_vld_c;
  logic                 disp_fire;
  logic                 iss_fire;
  logic                 byp_a;
  logic                 byp_b;

  assign disp_rdy_c  = ~(&vld);
  assign iss_vld_c   = |elig;
  assign disp_fire   = bus.disp_vld && disp_rdy_c;
  assign iss_fire    = iss_vld_c && bus.iss_rdy;
  assign bus.disp_rdy = disp_rdy_c;
  assign bus.iss_vld  = iss_vld_c;
  assign bus.rs_cnt   = cnt;

  // Eligibility and oldest-first pick: an eligible entry with no eligible older entry.
  always_comb begin
    elig   = vld & opa_rdy & opb_rdy;
    sel_oh = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      sel_oh[i] = elig[i] && ((elig & age[i]) == '0);
    end
  end

  // Issue mux; fields read zero when nothing is selected.
  always_comb begin
    sel_idx          = '0;
    bus.iss_dest_tag = '0;
    bus.iss_opa_tag  = '0;
    bus.iss_opb_tag  = '0;
    bus.iss_fu_sel   = '0;
    bus.iss_payload  = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (sel_oh[i]) begin
        sel_idx          = IDX_W'(i);
        bus.iss_dest_tag = dest_tag[i];
        bus.iss_opa_tag  = opa_tag[i];
        bus.iss_opb_tag  = opb_tag[i];
        bus.iss_fu_sel   = fu_sel[i];
        bus.iss_payload  = payload[i];
      end
    end
  end

  // Lowest-index free entry, from registered valid bits only.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IDX_W'(i);
    end
  end

  // Same-cycle CDB capture for the entry being dispatched.
  always_comb begin
`ifdef RS_DISP_BYPASS_EN
    byp_a = bus.cdb_vld && (bus.cdb_tag == bus.disp_opa_tag);
    byp_b = bus.cdb_vld && (bus.cdb_tag == bus.disp_opb_tag);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
  end

  // Entry state: wakeup, issue release, allocation, age tracking and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= '0;
      opa_rdy <= '0;
      opb_rdy <= '0;
      cnt     <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        dest_tag[i] <= '0;
        opa_tag[i]  <= '0;
        opb_tag[i]  <= '0;
        fu_sel[i]   <= '0;
        payload[i]  <= '0;
        age[i]      <= '0;
      end
    end else if (bus.flush) begin
      vld <= '0;
      cnt <= '0;
      for (int i = 0; i < NUM_ENT; i++) begin
        age[i] <= '0;
      end
    end else begin
      if (bus.cdb_vld) begin
        for (int i = 0; i < NUM_ENT; i++) begin
          if (vld[i] && (opa_tag[i] == bus.cdb_tag)) opa_rdy[i] <= 1'b1;
          if (vld[i] && (opb_tag[i] == bus.cdb_tag)) opb_rdy[i] <= 1'b1;
        end
      end
      if (iss_fire) begin
        vld[sel_idx] <= 1'b0;
      end
      if (disp_fire) begin
        // Stale "older" marks pointing at the reused slot are dropped first.
        for (int i = 0; i < NUM_ENT; i++) begin
          age[i][free_idx] <= 1'b0;
        end
        age[free_idx]      <= vld;
        vld[free_idx]      <= 1'b1;
        dest_tag[free_idx] <= bus.disp_dest_tag;
        opa_tag[free_idx]  <= bus.disp_opa_tag;
        opb_tag[free_idx]  <= bus.disp_opb_tag;
        opa_rdy[free_idx]  <= bus.disp_opa_rdy | byp_a;
        opb_rdy[free_idx]  <= bus.disp_opb_rdy | byp_b;
        fu_sel[free_idx]   <= bus.disp_fu_sel;
        payload[free_idx]  <= bus.disp_payload;
      end
      cnt <= cnt + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end
endmodule

// File: tb/tb_rs_array.sv
// Scoreboard bench for rs_array: an in-order queue model predicts each cycle's
// issue presentation, readiness and occupancy; a monitor compares the DUT.
module tb_rs_array;
  localparam int unsigned NE = 4;
  localparam int unsigned TW = 6;
  localparam int unsigned FW = 3;
  localparam int unsigned PW = 32;

  typedef struct {
    logic [TW-1:0] dest;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          ar;
    logic          br;
    logic [FW-1:0] fu;
    logic [PW-1:0] pl;
  } ent_t;

  typedef struct {
    logic          vld;
    logic [TW-1:0] dest;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [FW-1:0] fu;
    logic [PW-1:0] pl;
    logic          drdy;
    int            cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  ent_t q[$];
  exp_t exp_q[$];

  rs_if #(.NUM_ENT(NE), .TAG_W(TW), .FU_W(FW), .PAYLOAD_W(PW)) bus ();

  rs_array #(.NUM_ENT(NE), .TAG_W(TW), .FU_W(FW), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: entries kept oldest-first; evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    int   e;
    exp_t x;
    ent_t n;
    if (rst) begin
      q.delete();
    end else begin
      e = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (e < 0 && q[i].ar && q[i].br) e = i;
      end
      x = '{vld: 1'b0, dest: '0, a: '0, b: '0, fu: '0, pl: '0,
            drdy: (q.size() < NE), cnt: q.size()};
      if (e >= 0) begin
        x.vld  = 1'b1;
        x.dest = q[e].dest;
        x.a    = q[e].a;
        x.b    = q[e].b;
        x.fu   = q[e].fu;
        x.pl   = q[e].pl;
      end
      exp_q.push_back(x);
      if (bus.flush) begin
        q.delete();
      end else begin
        if (e >= 0 && bus.iss_rdy) q.delete(e);
        if (bus.cdb_vld) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].a == bus.cdb_tag) q[i].ar = 1'b1;
            if (q[i].b == bus.cdb_tag) q[i].br = 1'b1;
          end
        end
        if (bus.disp_vld && x.drdy) begin
          n.dest = bus.disp_dest_tag;
          n.a    = bus.disp_opa_tag;
          n.b    = bus.disp_opb_tag;
          n.ar   = bus.disp_opa_rdy;
          n.br   = bus.disp_opb_rdy;
`ifdef RS_DISP_BYPASS_EN
          if (bus.cdb_vld && bus.cdb_tag == bus.disp_opa_tag) n.ar = 1'b1;
          if (bus.cdb_vld && bus.cdb_tag == bus.disp_opb_tag) n.br = 1'b1;
`endif
          n.fu   = bus.disp_fu_sel;
          n.pl   = bus.disp_payload;
          q.push_back(n);
        end
      end
    end
  end

  // Monitor: pops the prediction for this cycle and compares DUT outputs.
  always @(negedge clk) begin
    exp_t x;
    #2;
    if (!rst) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
      end else begin
        x = exp_q.pop_front();
        check("disp_rdy", 64'(bus.disp_rdy), 64'(x.drdy));
        check("rs_cnt", 64'(bus.rs_cnt), 64'(x.cnt));
        check("iss_vld", 64'(bus.iss_vld), 64'(x.vld));
        check("iss_dest_tag", 64'(bus.iss_dest_tag), 64'(x.dest));
        check("iss_opa_tag", 64'(bus.iss_opa_tag), 64'(x.a));
        check("iss_opb_tag", 64'(bus.iss_opb_tag), 64'(x.b));
        check("iss_fu_sel", 64'(bus.iss_fu_sel), 64'(x.fu));
        check("iss_payload", 64'(bus.iss_payload), 64'(x.pl));
      end
    end
  end

  // One cycle of stimulus, held from just after one edge to just after the next.
  task automatic drive(input logic dv, input int dest, input int a, input int b,
                       input logic ar, input logic br, input logic cv, input int ct,
                       input logic ir, input logic fl);
    bus.disp_vld      = dv;
    bus.disp_dest_tag = TW'(dest);
    bus.disp_opa_tag  = TW'(a);
    bus.disp_opb_tag  = TW'(b);
    bus.disp_opa_rdy  = ar;
    bus.disp_opb_rdy  = br;
    bus.disp_fu_sel   = FW'($urandom);
    bus.disp_payload  = $urandom;
    bus.cdb_vld       = cv;
    bus.cdb_tag       = TW'(ct);
    bus.iss_rdy       = ir;
    bus.flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ir);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, ir, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    idle(1'b0);

    // Fill with four ready entries, no issue accepted.
    for (int i = 1; i <= 4; i++) drive(1'b1, i, 30, 31, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0);
    // Full and issuing: dispatch blocked this cycle, accepted next.
    drive(1'b1, 5, 30, 31, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 6, 30, 31, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (6) idle(1'b1);

    // Wakeup latency: waiting on tag 9.
    drive(1'b1, 5, 9, 31, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Younger ready entry overtakes an older waiting one.
    drive(1'b1, 7, 20, 31, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    drive(1'b1, 8, 30, 31, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 20, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Same-cycle dispatch and broadcast of tag 12.
    drive(1'b1, 10, 30, 12, 1'b1, 1'b0, 1'b1, 12, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Flush with three entries plus a concurrent dispatch.
    for (int i = 1; i <= 3; i++) drive(1'b1, 40 + i, 1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b1, 50, 30, 31, 1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1);
    idle(1'b1);

    // Mid-operation reset discards in-flight entries.
    for (int i = 1; i <= 3; i++) drive(1'b1, i, 30, 31, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1'b1);
    rst = 1'b0;
    repeat (2) idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
      end else begin
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
      end
    end

    repeat (3) idle(1'b0);
    @(negedge clk);
    #4;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_array.md
RS_ARRAY -- requirements
Module: rs_array

Interface
- REQ-001 SHALL have parameter NUM_ENT, default 4, number of entries (power of two, >=2).
- REQ-002 SHALL have parameter TAG_W, default 6, physical tag width.
- REQ-003 SHALL have parameter FU_W, default 3, function-unit select width.
- REQ-004 SHALL have parameter PAYLOAD_W, default 32, opaque opcode/immediate payload width.
- REQ-005 SHALL have port: clk  input  1  single clock, rising edge.
- REQ-006 SHALL have port: rst  input  1  reset, asynchronous, active-high.
- REQ-007 SHALL have port: disp_vld  input  1  dispatch request.
- REQ-008 SHALL have port: disp_rdy  output  1  an entry is free.
- REQ-009 SHALL have ports: disp_dest_tag, disp_opa_tag, disp_opb_tag  input  TAG_W each  destination and source tags.
- REQ-010 SHALL have ports: disp_opa_rdy, disp_opb_rdy  input  1 each  source already available.
- REQ-011 SHALL have ports: disp_fu_sel  input  FU_W, and disp_payload  input  PAYLOAD_W.
- REQ-012 SHALL have ports: cdb_vld  input  1, and cdb_tag  input  TAG_W  result broadcast.
- REQ-013 SHALL have port: iss_rdy  input  1  FU accepts an issue.
- REQ-014 SHALL have ports: iss_vld  output  1; iss_dest_tag, iss_opa_tag, iss_opb_tag  output  TAG_W; iss_fu_sel  output  FU_W; iss_payload  output  PAYLOAD_W.
- REQ-015 SHALL have port: flush  input  1  squash all entries.
- REQ-016 SHALL have port: rs_cnt  output  $clog2(NUM_ENT+1)  occupied entries.

Function
- REQ-017 disp_rdy SHALL equal NOT(all entries valid), from registered state only; it SHALL NOT count an entry issuing this cycle.
- REQ-018 A dispatch (disp_vld && disp_rdy) SHALL write the lowest-index free entry at the clock edge and set it valid.
- REQ-019 disp_vld while disp_rdy=0 SHALL be ignored, with no state change.
- REQ-020 Each entry SHALL hold opa_rdy/opb_rdy flags; cdb_vld with cdb_tag equal to a valid entry's source tag SHALL set that flag at the edge, in all matching entries and for both operands.
- REQ-021 An entry SHALL be eligible when valid && opa_rdy && opb_rdy (registered); a CDB wakeup SHALL make it eligible one cycle after the broadcast.
- REQ-022 Selection SHALL be oldest-first via an NUM_ENT x NUM_ENT age matrix; on allocation the new entry's row SHALL mark every currently valid entry as older.
- REQ-023 iss_vld SHALL be combinational from registered state, high when any entry is eligible; iss_* fields SHALL carry the selected entry and SHALL be zero when iss_vld=0.
- REQ-024 iss_vld && iss_rdy SHALL clear the selected entry's valid at the edge; the selection SHALL hold stable while iss_rdy=0 and no older entry becomes eligible.
- REQ-025 Dispatch, issue and CDB wakeup in the same cycle SHALL all take effect; the issuing entry SHALL NOT be reallocated in that cycle.
- REQ-026 rs_cnt SHALL be registered: +1 on dispatch, -1 on issue, unchanged on both, 0 after flush.
- REQ-027 flush SHALL clear all valid bits and age rows at the edge, overriding dispatch, issue and wakeup in that cycle.

Reset
- REQ-028 rst SHALL asynchronously clear all valid bits, ready flags, age matrix, stored fields and rs_cnt; after reset disp_rdy=1, iss_vld=0, all iss_* fields=0.
- REQ-029 rst asserted mid-operation SHALL discard all in-flight entries; no issue SHALL occur until new dispatches arrive after release.

Configuration
- REQ-030 With macro RS_DISP_BYPASS_EN defined, a dispatch SHALL record a source as ready when cdb_vld is high and cdb_tag equals that source tag in the same cycle; without it, disp_opX_rdy SHALL be stored unmodified and a same-cycle broadcast SHALL be missed.

Verification
- REQ-031 Reset, then dispatch 4 entries with dest tags 1..4, all sources ready, iss_rdy=0 -> disp_rdy=0, rs_cnt=4, iss_vld=1, iss_dest_tag=1.
- REQ-032 Dispatch dest 5 with opa_tag=9 not ready, then cdb_vld with tag 9 at cycle N -> iss_vld=1 with iss_dest_tag=5 at cycle N+1, not before.
- REQ-033 Dispatch A (dest 7, waiting) then B (dest 8, ready); wake A; hold iss_rdy=1 -> B issues first, then A (oldest eligible), rs_cnt 2->1->0.
- REQ-034 Full RS with iss_rdy=1 and disp_vld=1 -> no dispatch that cycle, rs_cnt 4->3; next cycle dispatch accepted, rs_cnt=4.
- REQ-035 Same-cycle dispatch with opb_tag=12 not ready and cdb_vld with tag 12 -> issues next cycle when RS_DISP_BYPASS_EN is defined; never issues when it is not.
- REQ-036 flush with 3 valid entries plus a concurrent dispatch -> rs_cnt=0, iss_vld=0, disp_rdy=1 next cycle.
